// File: rtl/mem_1rw_req_resp_adapter_pkg.sv
// Shared constants and helpers for the 1RW SRAM request/response adapter.
package mem_1rw_req_resp_adapter_pkg;

  localparam int unsigned resp_els_default_lp = 2;

  function automatic int unsigned mask_width(input int unsigned data_width);
    return data_width >> 3;
  endfunction

endpackage

// File: rtl/mem_1rw_req_resp_adapter_if.sv
// Request, SRAM-port and response signals of the adapter, bundled for port connection.
interface mem_1rw_req_resp_adapter_if
  import mem_1rw_req_resp_adapter_pkg::*;
#(
  parameter int unsigned width_p = 64,
  parameter int unsigned els_p   = 512
) ();

  localparam int unsigned addr_width_lp = $clog2(els_p);
  localparam int unsigned mask_width_lp = mask_width(width_p);

  logic                     v_i;
  logic                     w_i;
  logic [addr_width_lp-1:0] addr_i;
  logic [width_p-1:0]       data_i;
  logic [mask_width_lp-1:0] mask_i;
  logic                     ready_o;
  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [addr_width_lp-1:0] mem_addr_o;
  logic [width_p-1:0]       mem_data_o;
  logic [mask_width_lp-1:0] mem_mask_o;
  logic [width_p-1:0]       mem_data_i;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     ready_i;

  modport slave (
    input  v_i, w_i, addr_i, data_i, mask_i, mem_data_i, ready_i,
    output ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, v_o, data_o
  );

  modport master (
    output v_i, w_i, addr_i, data_i, mask_i, mem_data_i, ready_i,
    input  ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, v_o, data_o
  );

endinterface

// File: rtl/mem_1rw_resp_fifo.sv
// Small circular response FIFO with valid/ready on both sides; any depth >= 2.
module mem_1rw_resp_fifo #(
  parameter int unsigned width_p = 64,
  parameter int unsigned els_p   = 2,
  localparam int unsigned ptr_w_lp = $clog2(els_p),
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                ready_i,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign enq     = v_i & ready_o;
  assign deq     = v_o & ready_i;
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/mem_1rw_req_resp_adapter.sv
// Valid/ready front-end for a 1-cycle-latency 1RW SRAM: credit-gated requests,
// bypassed or FIFO-buffered read responses.
module mem_1rw_req_resp_adapter
  import mem_1rw_req_resp_adapter_pkg::*;
#(
  parameter int unsigned width_p    = 64,
  parameter int unsigned els_p      = 512,
  parameter int unsigned resp_els_p = resp_els_default_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  mem_1rw_req_resp_adapter_if.slave    bus
);

  localparam int unsigned addr_width_lp = $clog2(els_p);
  localparam int unsigned mask_width_lp = mask_width(width_p);
  localparam int unsigned cnt_w_lp      = $clog2(resp_els_p + 1);

  logic [addr_width_lp-1:0] req_addr;
  logic [mask_width_lp-1:0] req_mask;
  logic                     inflight_r;
  logic                     out_of_reset_r;
  logic                     fifo_enq_v, fifo_ready, fifo_v;
  logic [width_p-1:0]       fifo_data;
  logic [cnt_w_lp-1:0]      fifo_count;
  logic [cnt_w_lp:0]        occupancy;
  logic                     bypass;

  // Credits cover queued plus in-flight reads so the FIFO can never overflow;
  // out_of_reset_r holds ready_o low until the first clock after reset release.
  assign occupancy   = {1'b0, fifo_count} + (cnt_w_lp + 1)'(inflight_r);
  assign bus.ready_o = out_of_reset_r & fifo_ready
                     & (occupancy < (cnt_w_lp + 1)'(resp_els_p));

  assign req_addr       = bus.addr_i;
  assign req_mask       = bus.mask_i;
  assign bus.mem_v_o    = bus.v_i & bus.ready_o;
  assign bus.mem_w_o    = bus.w_i;
  assign bus.mem_addr_o = req_addr;
  assign bus.mem_data_o = bus.data_i;
  assign bus.mem_mask_o = req_mask;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inflight_r     <= 1'b0;
      out_of_reset_r <= 1'b0;
    end else begin
      inflight_r     <= bus.mem_v_o & ~bus.w_i;
      out_of_reset_r <= 1'b1;
    end
  end

  // Returning read data skips the FIFO only when nothing older is queued.
  assign bypass     = inflight_r & ~fifo_v;
  assign fifo_enq_v = inflight_r & ~(bypass & bus.ready_i);
  assign bus.v_o    = fifo_v | inflight_r;
  assign bus.data_o = fifo_v ? fifo_data : bus.mem_data_i;

  mem_1rw_resp_fifo #(
    .width_p (width_p),
    .els_p   (resp_els_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (fifo_enq_v),
    .data_i    (bus.mem_data_i),
    .ready_o   (fifo_ready),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .ready_i   (bus.ready_i),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_mem_1rw_req_resp_adapter.sv
// Directed bench for mem_1rw_req_resp_adapter with a behavioural 512x64 byte-masked SRAM.
module tb_mem_1rw_req_resp_adapter;

  logic clk;
  logic reset_n_i;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_1rw_req_resp_adapter_if #(.width_p(64), .els_p(512)) bus ();

  mem_1rw_req_resp_adapter #(
    .width_p    (64),
    .els_p      (512),
    .resp_els_p (2)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] sram [512];
  logic [63:0] sram_rd = '0;
  always @(posedge clk) begin
    if (bus.mem_v_o) begin
      if (bus.mem_w_o) begin
        for (int b = 0; b < 8; b++)
          if (bus.mem_mask_o[b]) sram[bus.mem_addr_o][b*8 +: 8] <= bus.mem_data_o[b*8 +: 8];
      end else begin
        sram_rd <= sram[bus.mem_addr_o];
      end
    end
  end
  assign bus.mem_data_i = sram_rd;

  always @(posedge clk) begin
    if (reset_n_i && dut.u_fifo.v_i && dut.u_fifo.count_o == 2) begin
      $display("FAIL fifo_overflow: enqueue with count %0d, required < 2", dut.u_fifo.count_o);
      n_fail++;
    end
  end

  typedef struct {
    bit          v, w;
    logic [8:0]  addr;
    logic [63:0] data;
    logic [7:0]  mask;
    bit          rdy;
    bit          e_ready, e_memv, e_v;
    logic [63:0] e_data;
  } vec_t;

  function automatic vec_t mk(bit v, bit w, logic [8:0] a, logic [63:0] d, logic [7:0] m,
                              bit r, bit er, bit em, bit ev, logic [63:0] ed);
    vec_t x;
    x.v = v; x.w = w; x.addr = a; x.data = d; x.mask = m; x.rdy = r;
    x.e_ready = er; x.e_memv = em; x.e_v = ev; x.e_data = ed;
    return x;
  endfunction

  function automatic logic [63:0] sv(int i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0101_0101);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
      n_fail++;
    end
  endtask

  task automatic drive(bit v, bit w, logic [8:0] a, logic [63:0] d, logic [7:0] m, bit r);
    bus.v_i = v; bus.w_i = w; bus.addr_i = a; bus.data_i = d; bus.mask_i = m; bus.ready_i = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [21];

  initial begin
    tbl[0]  = mk(1, 1, 9'h1A5, 64'h0123456789ABCDEF, 8'hFF, 1, 1, 1, 0, '0);
    tbl[1]  = mk(1, 0, 9'h1A5, '0,                   8'h00, 1, 1, 1, 0, '0);
    tbl[2]  = mk(0, 0, '0,     '0,                   8'h00, 1, 1, 0, 1, 64'h0123456789ABCDEF);
    tbl[3]  = mk(1, 1, 9'd3,   '0,                   8'hFF, 1, 1, 1, 0, '0);
    tbl[4]  = mk(1, 1, 9'd3,   '1,                   8'h81, 1, 1, 1, 0, '0);
    tbl[5]  = mk(1, 0, 9'd3,   '0,                   8'h00, 1, 1, 1, 0, '0);
    tbl[6]  = mk(0, 0, '0,     '0,                   8'h00, 1, 1, 0, 1, 64'hFF000000000000FF);
    tbl[7]  = mk(1, 1, 9'd1,   64'h11,               8'hFF, 1, 1, 1, 0, '0);
    tbl[8]  = mk(1, 1, 9'd2,   64'h22,               8'hFF, 1, 1, 1, 0, '0);
    tbl[9]  = mk(1, 1, 9'd3,   64'h33,               8'hFF, 1, 1, 1, 0, '0);
    tbl[10] = mk(1, 0, 9'd1,   '0,                   8'h00, 0, 1, 1, 0, '0);
    tbl[11] = mk(1, 0, 9'd2,   '0,                   8'h00, 0, 1, 1, 1, 64'h11);
    tbl[12] = mk(1, 0, 9'd3,   '0,                   8'h00, 0, 0, 0, 1, 64'h11);
    tbl[13] = mk(1, 0, 9'd3,   '0,                   8'h00, 0, 0, 0, 1, 64'h11);
    tbl[14] = mk(1, 0, 9'd3,   '0,                   8'h00, 1, 0, 0, 1, 64'h11);
    tbl[15] = mk(1, 0, 9'd3,   '0,                   8'h00, 1, 1, 1, 1, 64'h22);
    tbl[16] = mk(0, 0, '0,     '0,                   8'h00, 1, 1, 0, 1, 64'h33);
    tbl[17] = mk(0, 0, '0,     '0,                   8'h00, 1, 1, 0, 0, '0);
    tbl[18] = mk(1, 1, 9'd3,   '0,                   8'h00, 1, 1, 1, 0, '0);
    tbl[19] = mk(1, 0, 9'd3,   '0,                   8'h00, 1, 1, 1, 0, '0);
    tbl[20] = mk(0, 0, '0,     '0,                   8'h00, 1, 1, 0, 1, 64'h33);

    // Reset state, with a read request presented
    reset_n_i = 1'b0;
    drive(1, 0, 9'd0, '0, '0, 1);
    #2;
    chk("reset ready_o", 64'(bus.ready_o), 64'd0);
    chk("reset mem_v_o", 64'(bus.mem_v_o), 64'd0);
    chk("reset v_o", 64'(bus.v_o), 64'd0);
    drive(0, 0, '0, '0, '0, 1);
    #21;
    reset_n_i = 1'b1;
    next_cycle();

    // Table: write/readback, byte mask, backpressure, zero-mask write
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].rdy);
      #3;
      chk($sformatf("row%0d ready_o", i), 64'(bus.ready_o), 64'(tbl[i].e_ready));
      chk($sformatf("row%0d mem_v_o", i), 64'(bus.mem_v_o), 64'(tbl[i].e_memv));
      chk($sformatf("row%0d v_o", i), 64'(bus.v_o), 64'(tbl[i].e_v));
      if (tbl[i].e_v) chk($sformatf("row%0d data_o", i), bus.data_o, tbl[i].e_data);
      if (tbl[i].e_memv) begin
        chk($sformatf("row%0d mem_w_o", i), 64'(bus.mem_w_o), 64'(tbl[i].w));
        chk($sformatf("row%0d mem_addr_o", i), 64'(bus.mem_addr_o), 64'(tbl[i].addr));
      end
      next_cycle();
    end

    // Streaming: preload 0..15, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 9'(i), sv(i), 8'hFF, 1);
      next_cycle();
    end
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) drive(1, 0, 9'(c), '0, '0, 1);
      else        drive(0, 0, '0, '0, '0, 1);
      #3;
      chk($sformatf("stream%0d ready_o", c), 64'(bus.ready_o), 64'd1);
      chk($sformatf("stream%0d v_o", c), 64'(bus.v_o), (c == 0) ? 64'd0 : 64'd1);
      if (c > 0) chk($sformatf("stream%0d data_o", c), bus.data_o, sv(c - 1));
      next_cycle();
    end
    drive(0, 0, '0, '0, '0, 1);
    #3;
    chk("stream_end v_o", 64'(bus.v_o), 64'd0);
    next_cycle();

    // Credit gating of a write while the FIFO is full
    drive(1, 0, 9'd0, '0, '0, 0);
    next_cycle();
    drive(1, 0, 9'd1, '0, '0, 0);
    next_cycle();
    drive(1, 1, 9'd5, 64'hDEADBEEFCAFEF00D, 8'hFF, 0);
    #3;
    chk("gate_c ready_o", 64'(bus.ready_o), 64'd0);
    chk("gate_c mem_v_o", 64'(bus.mem_v_o), 64'd0);
    next_cycle();
    #3;
    chk("gate_d mem_v_o", 64'(bus.mem_v_o), 64'd0);
    chk("gate_d data_o", bus.data_o, sv(0));
    next_cycle();
    bus.ready_i = 1'b1;
    #3;
    chk("gate_e mem_v_o", 64'(bus.mem_v_o), 64'd0);
    chk("gate_e data_o", bus.data_o, sv(0));
    next_cycle();
    bus.ready_i = 1'b0;
    #3;
    chk("gate_f ready_o", 64'(bus.ready_o), 64'd1);
    chk("gate_f mem_v_o", 64'(bus.mem_v_o), 64'd1);
    chk("gate_f data_o", bus.data_o, sv(1));
    next_cycle();
    drive(0, 0, '0, '0, '0, 1);
    #3;
    chk("gate_g v_o", 64'(bus.v_o), 64'd1);
    chk("gate_g data_o", bus.data_o, sv(1));
    next_cycle();
    drive(1, 0, 9'd5, '0, '0, 1);
    next_cycle();
    drive(0, 0, '0, '0, '0, 1);
    #3;
    chk("gate_i v_o", 64'(bus.v_o), 64'd1);
    chk("gate_i data_o", bus.data_o, 64'hDEADBEEFCAFEF00D);
    next_cycle();

    // Reset with one read in flight and one queued response
    drive(1, 0, 9'd0, '0, '0, 0);
    next_cycle();
    drive(1, 0, 9'd1, '0, '0, 0);
    next_cycle();
    drive(0, 0, '0, '0, '0, 0);
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("rst_mid v_o", 64'(bus.v_o), 64'd0);
    chk("rst_mid ready_o", 64'(bus.ready_o), 64'd0);
    bus.ready_i = 1'b1;
    next_cycle();
    next_cycle();
    reset_n_i = 1'b1;
    #2;
    chk("rst_rel ready_o", 64'(bus.ready_o), 64'd0);
    next_cycle();
    chk("rst_post ready_o", 64'(bus.ready_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("rst_idle%0d v_o", i), 64'(bus.v_o), 64'd0);
      next_cycle();
    end
    drive(1, 0, 9'd2, '0, '0, 1);
    next_cycle();
    drive(0, 0, '0, '0, '0, 1);
    #2;
    chk("rst_new v_o", 64'(bus.v_o), 64'd1);
    chk("rst_new data_o", bus.data_o, sv(2));
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_1rw_req_resp_adapter.md
Name: mem_1rw_req_resp_adapter

Overview:
- Upstream front-end for the 512x64 byte-masked 1RW SRAM wrapper.
- Converts a valid/ready request stream (read or masked write) into single-cycle SRAM port accesses.
- Captures the SRAM's one-cycle-latency read data into a small response FIFO with valid/ready backpressure, so a stalled consumer never loses read data.
- Sits between the cache/engine request logic and the hardened memory.

Parameters:
- width_p, 64, data width in bits; must be a multiple of 8.
- els_p, 512, number of SRAM words.
- addr_width_lp, $clog2(els_p), address width (derived).
- mask_width_lp, width_p>>3, byte-mask width (derived).
- resp_els_p, 2, response FIFO depth; also the read credit limit; minimum 2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  request valid.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  addr_width_lp  request word address.
- data_i  in  width_p  write data.
- mask_i  in  mask_width_lp  write byte enables.
- ready_o  out  1  request accepted when v_i & ready_o.
- mem_v_o  out  1  SRAM access enable (wrapper v_i).
- mem_w_o  out  1  SRAM write (wrapper w_i).
- mem_addr_o  out  addr_width_lp  SRAM address.
- mem_data_o  out  width_p  SRAM write data.
- mem_mask_o  out  mask_width_lp  SRAM write mask.
- mem_data_i  in  width_p  SRAM read data, valid only the cycle after a read.
- v_o  out  1  response valid.
- data_o  out  width_p  response read data.
- ready_i  in  1  response consumer ready.

Behaviour:
- Single clock, clk_i. Reset is asynchronous, active-low on reset_n_i. All state clears immediately on assertion.
- Reset values: ready_o=0 while reset is asserted. mem_v_o=0, v_o=0. FIFO empty, inflight_r=0. data_o is don't-care.
- State:
  - inflight_r: set when a read is accepted, cleared the next cycle.
  - FIFO count: 0..resp_els_p.
- Credits: occupancy = fifo_count + inflight_r. ready_o = (occupancy < resp_els_p), computed from registered state only; it never depends on v_i or w_i.
- Credit gating applies to writes as well as reads.
- Accept: mem_v_o = v_i & ready_o. mem_w_o = w_i. mem_addr_o, mem_data_o and mem_mask_o pass through combinationally from the request.
- Writes produce no response.
- A write with mask_i=0 still drives mem_v_o=1 and changes no bytes.
- Read latency: read accepted in cycle T; data on mem_data_i in T+1.
  - Bypass: in T+1, if the FIFO is empty, v_o=1 and data_o=mem_data_i. If ready_i=1 the response completes in T+1 and nothing is enqueued.
  - Otherwise (FIFO non-empty, or ready_i=0) mem_data_i is enqueued at the end of T+1. v_o/data_o present the FIFO head.
- Ordering: responses are returned strictly in read-accept order.
- FIFO rules:
  - Enqueue and dequeue in the same cycle keeps the count.
  - Enqueue into a full FIFO is impossible by construction (credit rule). The bench asserts it never happens.
  - Pointers wrap modulo resp_els_p. Non-power-of-2 depths are supported.
- Throughput: with ready_i held 1, back-to-back reads are accepted every cycle (occupancy ≤1).
- Read after write to the same address in consecutive cycles returns the new data; the SRAM serialises the accesses.
- Reset mid-operation: an in-flight read and any queued responses are discarded. No response appears after reset deassertion until a new read is accepted.
- Reset deassertion: ready_o=1 from the first clock after reset_n_i rises.

Decomposition:
- Shared package: response-FIFO depth default, and a localparam helper for mask width (width_p>>3). Do not hard-code 8 in the adapter.
- One sub-module: mem_1rw_resp_fifo, parameterised width_p/els_p. It has ready/valid enqueue/dequeue, exposes count, and uses the same asynchronous active-low reset.
- Bypass mux and credit logic stay in the top level.

Test Plan:
- Reset: assert reset_n_i mid-run with a read in flight and 1 queued response -> v_o=0, ready_o=0 immediately; after release ready_o=1 and no stale response ever appears.
- Write/readback: write addr 0x1A5, data 0x0123456789ABCDEF, mask 0xFF; read 0x1A5 next cycle with ready_i=1 -> v_o=1 two cycles after the write accept, data_o=0x0123456789ABCDEF (bypass path).
- Byte mask: preload 0x0 at addr 3, then write 0xFFFFFFFFFFFFFFFF mask 0x81 -> readback 0xFF000000000000FF.
- Backpressure: ready_i=0, issue 3 reads of addrs 1,2,3 (contents 0x11,0x22,0x33) -> only 2 accepted, ready_o=0. Raise ready_i -> responses 0x11, 0x22 in order, then the third read is accepted and returns 0x33.
- Streaming: ready_i=1, 16 consecutive reads of addrs 0..15 -> ready_o stays 1, 16 in-order responses in 16 consecutive cycles starting 1 cycle after the first accept.
- Credit gating of writes: FIFO full (2 responses, ready_i=0), present a write -> not accepted, mem_v_o=0. After one dequeue the write is accepted next cycle.
